// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM.
// Each access takes three cycles: IDLE (arbitrate), ACCESS (drive RAM), RESP (report).
// Optional macro RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it port 0 always wins a tie.
module ram_arbiter #(
  parameter int unsigned TAM_POSICIONES = 1024,
  parameter int unsigned TAM_PALABRA    = 32,
  localparam int unsigned AW = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   REQ0,
  input  logic                   REQ1,
  input  logic                   WE0,
  input  logic                   WE1,
  input  logic [AW-1:0]          ADDR0,
  input  logic [AW-1:0]          ADDR1,
  input  logic [TAM_PALABRA-1:0] WDATA0,
  input  logic [TAM_PALABRA-1:0] WDATA1,
  output logic                   GNT0,
  output logic                   GNT1,
  output logic                   VALID0,
  output logic                   VALID1,
  output logic [TAM_PALABRA-1:0] RDATA0,
  output logic [TAM_PALABRA-1:0] RDATA1,
  output logic                   RAM_WR,
  output logic                   RAM_OE,
  output logic [AW-1:0]          RAM_ADDR,
  output logic [TAM_PALABRA-1:0] RAM_DIN,
  input  logic [TAM_PALABRA-1:0] RAM_DOUT,
  output logic                   BUSY
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   idx_q;
  logic                   we_q;
  logic [AW-1:0]          addr_q;
  logic [TAM_PALABRA-1:0] din_q;
  logic [1:0]             gnt_q;
  logic [1:0]             valid_q;
  logic [TAM_PALABRA-1:0] rdata0_q, rdata1_q;
  logic                   req_any;
  logic                   win;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Tie goes to the port that was not served last; otherwise the lone requester wins.
  always_comb begin
    if (REQ0 && REQ1) win = ~last_q;
    else              win = ~REQ0;
  end
`else
  // Fixed priority: port 0 wins whenever it requests.
  always_comb begin
    win = ~REQ0;
  end
`endif

  assign req_any = REQ0 | REQ1;

  // Next-state logic: IDLE waits for a request, ACCESS and RESP advance unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_any) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath and handshake registers; request fields are latched only at the winning IDLE edge.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      state_q  <= StIdle;
      idx_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      gnt_q    <= 2'b00;
      valid_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= 2'b00;
      valid_q <= 2'b00;
      if (state_q == StIdle && req_any) begin
        idx_q  <= win;
        we_q   <= win ? WE1 : WE0;
        addr_q <= win ? ADDR1 : ADDR0;
        din_q  <= win ? WDATA1 : WDATA0;
        gnt_q  <= win ? 2'b10 : 2'b01;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_q <= win;
`endif
      end
      if (state_q == StAccess) begin
        valid_q <= gnt_q;
        if (!we_q) begin
          if (idx_q) rdata1_q <= RAM_DOUT;
          else       rdata0_q <= RAM_DOUT;
        end
      end
    end
  end

  // RAM strobes only in ACCESS, and suppressed combinationally while reset is high.
  always_comb begin
    RAM_WR = 1'b0;
    RAM_OE = 1'b0;
    if (state_q == StAccess && !RSTa) begin
      RAM_WR = we_q;
      RAM_OE = ~we_q;
    end
  end

  assign RAM_ADDR = addr_q;
  assign RAM_DIN  = din_q;
  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign VALID0   = valid_q[0];
  assign VALID1   = valid_q[1];
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign BUSY     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and transaction-level model.
module tb_ram_arbiter;

  localparam int unsigned N  = 1024;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, valid0, valid1;
  logic [W-1:0]  rdata0, rdata1;
  logic          ram_wr, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din, ram_dout;
  logic          busy;

  always #5 clk = ~clk;

  ram_arbiter #(.TAM_POSICIONES(N), .TAM_PALABRA(W)) dut (
    .CLK(clk), .RSTa(rst),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT0(gnt0), .GNT1(gnt1), .VALID0(valid0), .VALID1(valid1),
    .RDATA0(rdata0), .RDATA1(rdata1),
    .RAM_WR(ram_wr), .RAM_OE(ram_oe), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din),
    .RAM_DOUT(ram_dout), .BUSY(busy)
  );

  // Behavioural RAM: asynchronous read when enabled, write on the clock edge.
  logic [W-1:0] mem [N];
  assign ram_dout = (ram_oe && !ram_wr) ? mem[ram_addr] : 32'hBAD0_BAD0;
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_din;

  // Reference model state.
  logic [W-1:0] exp_mem [N];
  logic [W-1:0] exp_rdata [2];
  int           last;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input bit r0, input bit r1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (r0 && r1) return (last == 0) ? 1 : 0;
`endif
    return r0 ? 0 : 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req0 = 0; req1 = 0;
    step(); step();
    rst = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0; last = 1;
  endtask

  // One transaction driven from IDLE; checks every cycle until back in IDLE.
  task automatic do_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input bit scr, output int win);
    bit           we;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    check("idle_busy", busy, 0);
    check("idle_gnt", {gnt1, gnt0}, 0);
    check("idle_valid", {valid1, valid0}, 0);
    check("idle_strobes", {ram_wr, ram_oe}, 0);
    step();
    if (!r0 && !r1) begin
      check("noreq_busy", busy, 0);
      win = -1;
      return;
    end
    win  = pick(r0, r1);
    last = win;
    we = (win == 0) ? w0 : w1;
    a  = (win == 0) ? a0 : a1;
    d  = (win == 0) ? d0 : d1;
    check("acc_gnt", {gnt1, gnt0}, (win == 0) ? 2'b01 : 2'b10);
    check("acc_wr", ram_wr, we);
    check("acc_oe", ram_oe, !we);
    check("acc_addr", ram_addr, a);
    check("acc_din", ram_din, d);
    check("acc_busy", busy, 1);
    if (scr) begin
      req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom); wdata0 = $urandom; wdata1 = $urandom;
    end else begin
      req0 = 0; req1 = 0;
    end
    step();
    if (we) exp_mem[a] = d;
    else    exp_rdata[win] = exp_mem[a];
    check("resp_valid", {valid1, valid0}, (win == 0) ? 2'b01 : 2'b10);
    check("resp_gnt", {gnt1, gnt0}, 0);
    check("resp_strobes", {ram_wr, ram_oe}, 0);
    check("resp_addr_hold", ram_addr, a);
    check("resp_rdata0", rdata0, exp_rdata[0]);
    check("resp_rdata1", rdata1, exp_rdata[1]);
    check("resp_busy", busy, 1);
    req0 = 0; req1 = 0;
    step();
  endtask

  int w;
  int order [4];

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i] = '0; exp_mem[i] = '0;
    end
    {req0, req1, we0, we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    do_reset();
    check("rst_outs", {gnt0, gnt1, valid0, valid1, busy, ram_wr, ram_oe}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);

    // Write then cross-port read of the same word.
    do_txn(1, 0, 1, 0, 5, 0, 32'hDEADBEEF, 0, 0, w);
    check("wr_rdata0", rdata0, 0);
    do_txn(0, 1, 0, 0, 0, 5, 0, 0, 0, w);
    check("rd_rdata1", rdata1, 32'hDEADBEEF);

    // Address change during ACCESS must not disturb the latched read.
    do_txn(1, 0, 1, 0, 3, 0, 32'hCAFE0003, 0, 0, w);
    do_txn(1, 0, 1, 0, 9, 0, 32'h00000009, 0, 0, w);
    req0 = 1; we0 = 0; addr0 = 3; req1 = 0;
    step();
    addr0 = 9;
    step();
    check("hold_addr", ram_addr, 3);
    check("hold_rdata0", rdata0, 32'hCAFE0003);
    exp_rdata[0] = 32'hCAFE0003;
    last = 0;
    req0 = 0;
    step();

    // Reset during ACCESS of a write aborts it.
    req0 = 1; we0 = 1; addr0 = 7; wdata0 = 32'h12345678; req1 = 0;
    step();
    check("abort_gnt", gnt0, 1);
    rst = 1; req0 = 0;
    #1;
    check("abort_wr", ram_wr, 0);
    step();
    rst = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0; last = 1;
    check("abort_valid", {valid1, valid0}, 0);
    check("abort_busy", busy, 0);
    do_txn(0, 1, 0, 0, 0, 7, 0, 0, 0, w);
    checks++;
    if (rdata1 === 32'h12345678) begin
      errors++;
      $display("FAIL abort_rd: got %h expected not 12345678", rdata1);
    end

    // Both ports requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, 0, 0, AW'(i), AW'(i + 8), 0, 0, 0, w);
      order[i] = w;
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check("order0", order[0], 0); check("order1", order[1], 1);
    check("order2", order[2], 0); check("order3", order[3], 1);
`else
    check("order0", order[0], 0); check("order1", order[1], 0);
    check("order2", order[2], 0); check("order3", order[3], 0);
`endif

    // Randomized traffic over a small address window to force reuse.
    for (int i = 0; i < 300; i++) begin
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
             $urandom, $urandom, 1'($urandom), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter TAM_POSICIONES, default 1024, meaning the number of RAM words; AW = $clog2(TAM_POSICIONES).
REQ-002 The block SHALL have parameter TAM_PALABRA, default 32, meaning the RAM word width W.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RSTa  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports REQ0/REQ1  input  1  access request from requester 0/1.
REQ-006 The block SHALL have ports WE0/WE1  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports ADDR0/ADDR1  input  AW  word address.
REQ-008 The block SHALL have ports WDATA0/WDATA1  input  W  write data.
REQ-009 The block SHALL have ports GNT0/GNT1  output  1  one-cycle grant pulse.
REQ-010 The block SHALL have ports VALID0/VALID1  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports RDATA0/RDATA1  output  W  read data.
REQ-012 The block SHALL have ports RAM_WR, RAM_OE  output  1  RAM write enable / output enable.
REQ-013 The block SHALL have ports RAM_ADDR  output  AW, RAM_DIN  output  W  RAM address / write data.
REQ-014 The block SHALL have port RAM_DOUT  input  W  RAM read data, combinational from RAM_ADDR when RAM_OE=1 and RAM_WR=0.
REQ-015 The block SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, ACCESS, RESP; transitions: IDLE->ACCESS when any REQ is high, ACCESS->RESP, RESP->IDLE, unconditionally.
REQ-017 At the IDLE edge where a requester wins, the block SHALL latch that port's ADDR, WE, WDATA and its index, and assert its GNT (registered) for exactly the ACCESS cycle.
REQ-018 In ACCESS, the block SHALL drive RAM_ADDR/RAM_DIN from the latched values, RAM_WR = latched WE, RAM_OE = NOT latched WE.
REQ-019 For reads, the block SHALL capture RAM_DOUT into RDATA of the granted port at the ACCESS->RESP edge; the other port's RDATA SHALL hold.
REQ-020 VALID of the granted port SHALL be high for exactly the RESP cycle, for reads and writes alike.
REQ-021 Latency SHALL be fixed: GNT in cycle N+1, RAM access in cycle N+1, VALID in cycle N+2, where REQ is sampled at the end of IDLE cycle N; throughput is one access per 3 cycles.
REQ-022 Requesters SHALL hold REQ/ADDR/WE/WDATA stable until GNT; inputs after the grant edge SHALL be ignored until the next IDLE.
REQ-023 A REQ still high during RESP SHALL be treated as a new request at the following IDLE edge.
REQ-024 Outside ACCESS, RAM_WR and RAM_OE SHALL be 0; RAM_ADDR/RAM_DIN SHALL hold their last values.
REQ-025 Simultaneous REQ0 and REQ1 SHALL be resolved per REQ-031/REQ-032; exactly one GNT SHALL ever be high in any cycle.
REQ-026 RDATAx SHALL hold its last captured value until the next read completes on that port.

Reset
REQ-027 While RSTa=1, RAM_WR and RAM_OE SHALL be forced 0 combinationally so no write commits at that edge.
REQ-028 At a rising edge with RSTa=1, the block SHALL set state to IDLE, GNT0/1, VALID0/1 and BUSY to 0, RDATA0/1, RAM_ADDR and RAM_DIN to 0, and the last-served pointer to 1.
REQ-029 Reset asserted during ACCESS or RESP SHALL abort the transaction with no VALID pulse.

Configuration
REQ-030 Macro RAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 With the macro defined, on a tie the block SHALL grant the port not equal to the last-served pointer, then update the pointer to the granted port.
REQ-032 With the macro undefined, port 0 SHALL always win ties; the pointer is absent.

Verification
REQ-033 Reset then REQ0=1, WE0=1, ADDR0=5, WDATA0=0xDEADBEEF -> GNT0 next cycle with RAM_WR=1, RAM_ADDR=5; VALID0 the cycle after; RDATA0 stays 0.
REQ-034 Then REQ1=1, WE1=0, ADDR1=5 -> RAM_OE=1 in ACCESS; RDATA1=0xDEADBEEF with VALID1 in RESP.
REQ-035 REQ0 and REQ1 held high for 4 transactions, macro defined -> grant order 0,1,0,1; macro undefined -> 0,0,0,0.
REQ-036 RSTa=1 in the ACCESS cycle of a write to ADDR 7 with data 0x12345678 -> RAM_WR=0 that cycle; no VALID; a later read of ADDR 7 does not return 0x12345678.
REQ-037 ADDR0 changed from 3 to 9 during ACCESS of a read -> RAM_ADDR stays 3; RDATA0 = word at 3.
